// File: rtl/led_frame_scheduler_if.sv
// Frame buffer read port and encoder pixel handshake between the scheduler (master)
// and the frame buffer / bit encoder (slave).
interface led_frame_scheduler_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [23:0]           mem_data;
    logic [23:0]           pixel_data;
    logic                  pixel_valid;
    logic                  pixel_ready;

    modport master (
        output mem_addr, mem_rd, pixel_data, pixel_valid,
        input  mem_data, pixel_ready
    );

    modport slave (
        input  mem_addr, mem_rd, pixel_data, pixel_valid,
        output mem_data, pixel_ready
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Walks the pixel frame buffer once per accepted frame tick, streams GRB words to the
// bit encoder, then holds the encoder in latch/reset for LATCH_BITS bit periods.
module led_frame_scheduler #(
    parameter int LED_COUNT  = 60,
    parameter int ADDR_WIDTH = 8,
    parameter int LATCH_BITS = 40
) (
    input  logic                        clock_12mhz,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic                        i_frame_tick,
    input  logic                        i_bit_tick,
    led_frame_scheduler_if.master       bus,
    output logic                        o_encoder_reset,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic [7:0]                  o_overrun_count
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

    localparam int CNT_W = (LATCH_BITS > 1) ? $clog2(LATCH_BITS) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(LATCH_BITS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LED_COUNT - 1);

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_latch_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rd;
    logic [23:0]           r_pixel_data;
    logic                  r_pixel_valid;
    logic                  r_encoder_reset;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [7:0]            r_overrun_count;
    logic                  w_overrun;

    assign w_overrun = i_frame_tick && i_enable && (r_state != ST_IDLE);

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_latch_cnt     <= '0;
            r_mem_addr      <= '0;
            r_mem_rd        <= 1'b0;
            r_pixel_data    <= '0;
            r_pixel_valid   <= 1'b0;
            r_encoder_reset <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_mem_rd     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_tick && i_enable) begin
                        r_state    <= ST_FETCH;
                        r_mem_addr <= '0;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_pixel_data  <= bus.mem_data;
                    r_pixel_valid <= 1'b1;
                    r_state       <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_pixel_valid && bus.pixel_ready) begin
                        r_pixel_valid <= 1'b0;
                        if (r_mem_addr == LAST_ADDR) begin
                            r_state         <= ST_LATCH;
                            r_latch_cnt     <= '0;
                            r_encoder_reset <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                            r_mem_rd   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_LATCH: begin
                    // Counter holds ticks already seen, so the LATCH_BITS-th tick exits directly.
                    if (i_bit_tick) begin
                        if (r_latch_cnt == LAST_CNT) begin
                            r_state         <= ST_IDLE;
                            r_encoder_reset <= 1'b0;
                            r_frame_done    <= 1'b1;
                            r_mem_addr      <= '0;
                            r_busy          <= 1'b0;
                        end else begin
                            r_latch_cnt <= r_latch_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            r_overrun_count <= '0;
        end else if (w_overrun && (r_overrun_count != 8'hFF)) begin
            r_overrun_count <= r_overrun_count + 8'd1;
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.pixel_data  = r_pixel_data;
    assign bus.pixel_valid = r_pixel_valid;
    assign o_encoder_reset = r_encoder_reset;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;
    assign o_overrun_count = r_overrun_count;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench: a 3-pixel/4-bit-latch scheduler for the main scenarios and a
// 1-pixel/1-bit-latch scheduler for the boundary case, sharing one clock and reset.
module tb_led_frame_scheduler;
    logic clock = 1'b0;
    logic reset;
    logic enA, tickA, bitA;
    logic enB, tickB, bitB;
    logic encA, busyA, doneA;
    logic encB, busyB, doneB;
    logic [7:0] ovrA, ovrB;
    int checks = 0;
    int failures = 0;

    led_frame_scheduler_if #(.ADDR_WIDTH(8)) busA ();
    led_frame_scheduler_if #(.ADDR_WIDTH(8)) busB ();

    led_frame_scheduler #(.LED_COUNT(3), .ADDR_WIDTH(8), .LATCH_BITS(4)) dutA (
        .clock_12mhz(clock), .reset(reset), .i_enable(enA), .i_frame_tick(tickA),
        .i_bit_tick(bitA), .bus(busA), .o_encoder_reset(encA), .o_busy(busyA),
        .o_frame_done(doneA), .o_overrun_count(ovrA)
    );

    led_frame_scheduler #(.LED_COUNT(1), .ADDR_WIDTH(8), .LATCH_BITS(1)) dutB (
        .clock_12mhz(clock), .reset(reset), .i_enable(enB), .i_frame_tick(tickB),
        .i_bit_tick(bitB), .bus(busB), .o_encoder_reset(encB), .o_busy(busyB),
        .o_frame_done(doneB), .o_overrun_count(ovrB)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] pixA(input logic [7:0] addr);
        case (addr)
            8'd0:    return 24'h110000;
            8'd1:    return 24'h002200;
            8'd2:    return 24'h000033;
            default: return 24'h000000;
        endcase
    endfunction

    // Frame buffers answer one cycle after the read strobe.
    initial begin
        busA.mem_data = '0;
        busB.mem_data = '0;
    end

    always @(posedge clock) begin
        if (busA.mem_rd) busA.mem_data <= pixA(busA.mem_addr);
        if (busB.mem_rd) busB.mem_data <= (busB.mem_addr == 8'd0) ? 24'hABCDEF : 24'h0;
    end

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ends in the cycle right after the edge that sampled the last pulse.
    task automatic latchA(input int n);
        for (int i = 0; i < n; i++) begin
            bitA = 1'b1;
            applyStimulus(1);
            bitA = 1'b0;
            if (i < n - 1) applyStimulus(1);
        end
    endtask

    initial begin
        reset = 1'b1;
        enA = 1'b1; tickA = 1'b0; bitA = 1'b0; busA.pixel_ready = 1'b1;
        enB = 1'b1; tickB = 1'b0; bitB = 1'b0; busB.pixel_ready = 1'b1;
        applyStimulus(3);
        reset = 1'b0;
        checkOutput("reset_A_ctrl", {busA.mem_addr, busA.mem_rd, busA.pixel_valid, encA, busyA, doneA, ovrA}, 32'd0);
        checkOutput("reset_A_data", busA.pixel_data, 32'd0);
        checkOutput("reset_B_ctrl", {busB.mem_addr, busB.mem_rd, busB.pixel_valid, encB, busyB, doneB, ovrB}, 32'd0);

        // Basic frame, ready always high.
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        checkOutput("c1_fetch0", {busA.mem_rd, busyA, busA.mem_addr}, {1'b1, 1'b1, 8'd0});
        applyStimulus(1);
        checkOutput("c2_wait0", {busA.mem_rd, busA.pixel_valid}, 2'b00);
        applyStimulus(1);
        checkOutput("c3_pix0", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h110000});
        applyStimulus(1);
        checkOutput("c4_fetch1", {busA.mem_rd, busA.mem_addr, busA.pixel_valid}, {1'b1, 8'd1, 1'b0});
        applyStimulus(2);
        checkOutput("c6_pix1", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h002200});
        applyStimulus(3);
        checkOutput("c9_pix2", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h000033});
        applyStimulus(1);
        checkOutput("c10_latch", {encA, busyA, busA.pixel_valid, busA.mem_rd}, 4'b1100);
        latchA(3);
        checkOutput("latch_3ticks", {encA, doneA}, 2'b10);
        latchA(1);
        checkOutput("latch_exit", {doneA, encA, busyA, busA.mem_addr}, {1'b1, 1'b0, 1'b0, 8'd0});
        applyStimulus(1);
        checkOutput("done_one_cycle", {doneA, ovrA}, {1'b0, 8'd0});

        // Backpressure on pixel 1 with one overrun tick during SEND.
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        applyStimulus(3);
        busA.pixel_ready = 1'b0;
        applyStimulus(2);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold", {busA.pixel_valid, busA.pixel_data, busA.mem_rd}, {1'b1, 24'h002200, 1'b0});
            tickA = (i == 3);
            applyStimulus(1);
        end
        tickA = 1'b0;
        checkOutput("bp_hold_end", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h002200});
        busA.pixel_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_accept", {busA.pixel_valid, busA.mem_rd, busA.mem_addr}, {1'b0, 1'b1, 8'd2});
        applyStimulus(2);
        checkOutput("bp_pix2", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h000033});
        applyStimulus(1);
        tickA = 1'b1;
        applyStimulus(2);
        tickA = 1'b0;
        latchA(4);
        checkOutput("ovr_frame_done", {doneA, busyA}, 2'b10);
        checkOutput("ovr_count3", ovrA, 32'd3);
        applyStimulus(3);
        checkOutput("ovr_no_extra_frame", {busyA, busA.mem_rd}, 2'b00);

        // Tick with enable low is ignored.
        enA = 1'b0;
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        checkOutput("en_low_ignored", {busA.mem_rd, busyA, ovrA}, {1'b0, 1'b0, 8'd3});

        // Enable drops mid-SEND; the frame and latch still complete.
        enA = 1'b1;
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        applyStimulus(2);
        enA = 1'b0;
        applyStimulus(1);
        checkOutput("en_drop_fetch1", {busA.mem_rd, busA.mem_addr}, {1'b1, 8'd1});
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        applyStimulus(5);
        checkOutput("en_drop_latch", {encA, busyA}, 2'b11);
        latchA(4);
        checkOutput("en_drop_done", {doneA, encA, busyA}, 3'b100);
        applyStimulus(1);
        checkOutput("en_drop_idle", {doneA, busyA, ovrA}, {1'b0, 1'b0, 8'd3});
        enA = 1'b1;

        // Reset at cycle 7 of a frame.
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        applyStimulus(6);
        checkOutput("pre_reset_c7", {busA.mem_rd, busA.mem_addr, busA.pixel_data}, {1'b1, 8'd2, 24'h002200});
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("midreset_ctrl", {busA.mem_addr, busA.mem_rd, busA.pixel_valid, encA, busyA, doneA, ovrA}, 32'd0);
        checkOutput("midreset_data", busA.pixel_data, 32'd0);
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        checkOutput("restart_fetch0", {busA.mem_rd, busA.mem_addr, busyA}, {1'b1, 8'd0, 1'b1});
        applyStimulus(2);
        checkOutput("restart_pix0", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h110000});
        applyStimulus(7);
        checkOutput("restart_latch", encA, 32'd1);
        latchA(4);
        checkOutput("restart_done", doneA, 32'd1);
        applyStimulus(1);

        // Overrun saturation while stalled in SEND.
        tickA = 1'b1;
        applyStimulus(1);
        tickA = 1'b0;
        busA.pixel_ready = 1'b0;
        applyStimulus(2);
        tickA = 1'b1;
        applyStimulus(255);
        checkOutput("sat_255", ovrA, 32'd255);
        applyStimulus(45);
        tickA = 1'b0;
        checkOutput("sat_no_wrap", ovrA, 32'd255);
        checkOutput("sat_stalled", {busA.pixel_valid, busA.pixel_data}, {1'b1, 24'h110000});
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        busA.pixel_ready = 1'b1;

        // Boundary: one pixel, one-bit latch.
        tickB = 1'b1;
        applyStimulus(1);
        tickB = 1'b0;
        checkOutput("b_fetch0", {busB.mem_rd, busB.mem_addr, busyB}, {1'b1, 8'd0, 1'b1});
        applyStimulus(2);
        checkOutput("b_pix0", {busB.pixel_valid, busB.pixel_data}, {1'b1, 24'hABCDEF});
        bitB = 1'b1;
        applyStimulus(1);
        bitB = 1'b0;
        checkOutput("b_latch_entry", {encB, doneB, busyB}, 3'b101);
        applyStimulus(1);
        checkOutput("b_entry_tick_ignored", {encB, doneB}, 2'b10);
        bitB = 1'b1;
        tickB = 1'b1;
        applyStimulus(1);
        bitB = 1'b0;
        tickB = 1'b0;
        checkOutput("b_exit", {doneB, encB, busyB, ovrB}, {1'b1, 1'b0, 1'b0, 8'd1});
        applyStimulus(1);
        checkOutput("b_after_exit", {doneB, busB.mem_rd, busyB}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
